// File: rtl/mv_stream_engine.sv
// mv_stream_engine
// ----------------
// Weight-stationary signed matrix-vector engine. A ROWS x COLS weight matrix is
// written through the addressed config port. Each input vector streamed in
// produces y = W * x. One column is accumulated per cycle for all rows at once,
// so a vector takes COLS compute cycles. Accumulation either saturates (SAT=1)
// or wraps (SAT=0). A sticky per-row overflow flag is reported with each result.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_valid/ready    weight write handshake; cfg_addr = {row, col}, cfg_data
//   x_valid/ready      input vector handshake; x_vector_flat element c at [c*DW +: DW]
//   y_valid/ready      result handshake; result_flat row r at [r*ACC_W +: ACC_W]
//   ovf_flat           bit r set if row r overflowed while computing this vector
//   busy               high while a vector is being computed or presented
module mv_stream_engine #(
    parameter int DW    = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ROW_W = 2,
    parameter int COL_W = 2,
    parameter int ACC_W = 20,
    parameter int SAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ROW_W+COL_W-1:0] cfg_addr,
    input  logic [DW-1:0]          cfg_data,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [COLS*DW-1:0]     x_vector_flat,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [ROWS*ACC_W-1:0]  result_flat,
    output logic [ROWS-1:0]        ovf_flat,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state, state_next;

    logic signed [DW-1:0]      weight [ROWS][COLS];
    logic signed [DW-1:0]      x_reg [COLS];
    logic signed [ACC_W-1:0]   acc [ROWS];
    logic signed [ACC_W-1:0]   acc_next [ROWS];
    logic [ROWS-1:0]           ovf;
    logic [ROWS-1:0]           ovf_step;
    logic [COL_W-1:0]          col_cnt;
    logic                      last_col;
    logic                      cfg_fire;
    logic                      x_fire;

    logic [ROW_W-1:0]          cfg_row;
    logic [COL_W-1:0]          cfg_col;

    logic signed [DW-1:0]      w_sel [ROWS];
    logic signed [DW-1:0]      x_sel;
    logic signed [2*DW-1:0]    prod [ROWS];
    logic signed [ACC_W:0]     sum [ROWS];

    assign cfg_row  = cfg_addr[ROW_W+COL_W-1:COL_W];
    assign cfg_col  = cfg_addr[COL_W-1:0];
    assign last_col = (col_cnt == COL_W'(COLS-1));
    assign cfg_fire = cfg_valid && cfg_ready;
    assign x_fire   = x_valid && x_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Config has priority over a vector in IDLE.
    always_comb begin
        state_next = state;
        cfg_ready  = 1'b0;
        x_ready    = 1'b0;
        y_valid    = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                x_ready   = !cfg_valid;
                if (x_valid && !cfg_valid) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (last_col) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                busy    = 1'b1;
                y_valid = 1'b1;
                if (y_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One column step for every row: product is sign-extended and the sum is
    // formed one bit wider than the accumulator so overflow can be detected as
    // a disagreement between the two top bits.
    always_comb begin
        x_sel = x_reg[0];
        for (int c = 0; c < COLS; c++) begin
            if (col_cnt == COL_W'(c)) x_sel = x_reg[c];
        end
        for (int r = 0; r < ROWS; r++) begin
            w_sel[r] = weight[r][0];
            for (int c = 0; c < COLS; c++) begin
                if (col_cnt == COL_W'(c)) w_sel[r] = weight[r][c];
            end
            prod[r]     = (2*DW)'(w_sel[r]) * (2*DW)'(x_sel);
            sum[r]      = (ACC_W+1)'(acc[r]) + (ACC_W+1)'(prod[r]);
            ovf_step[r] = (sum[r][ACC_W] != sum[r][ACC_W-1]);
            if (ovf_step[r] && (SAT != 0)) begin
                acc_next[r] = sum[r][ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_next[r] = sum[r][ACC_W-1:0];
            end
        end
    end

    // Weight store, input latch and accumulators. Out-of-range config
    // addresses match no (row, col) pair and are therefore dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                acc[r] <= '0;
                for (int c = 0; c < COLS; c++) weight[r][c] <= '0;
            end
            for (int c = 0; c < COLS; c++) x_reg[c] <= '0;
            ovf     <= '0;
            col_cnt <= '0;
        end else begin
            if (cfg_fire) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (cfg_row == ROW_W'(r) && cfg_col == COL_W'(c)) begin
                            weight[r][c] <= cfg_data;
                        end
                    end
                end
            end
            if (state == IDLE && x_fire) begin
                for (int c = 0; c < COLS; c++) x_reg[c] <= x_vector_flat[c*DW +: DW];
                for (int r = 0; r < ROWS; r++) acc[r] <= '0;
                ovf     <= '0;
                col_cnt <= '0;
            end else if (state == COMPUTE) begin
                for (int r = 0; r < ROWS; r++) acc[r] <= acc_next[r];
                ovf     <= ovf | ovf_step;
                col_cnt <= col_cnt + COL_W'(1);
            end
        end
    end

    // Results come straight from the accumulators, so they hold after the
    // handshake until the next vector is accepted.
    always_comb begin
        for (int r = 0; r < ROWS; r++) result_flat[r*ACC_W +: ACC_W] = acc[r];
    end

    assign ovf_flat = ovf;

endmodule

// File: tb/tb_mv_stream_engine.sv
// tb_mv_stream_engine
// -------------------
// Directed bench for mv_stream_engine. Instance A (ROWS=3, COLS=2, ACC_W=16,
// saturating) carries most steps; instance B (ROWS=2, COLS=2, ACC_W=16,
// wrapping) covers the two's-complement overflow case.
module tb_mv_stream_engine;

    localparam int DW    = 8;
    localparam int ACC_W = 16;

    logic clk = 1'b0;
    logic rst_n;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    logic        a_cfg_valid, a_cfg_ready;
    logic [2:0]  a_cfg_addr;
    logic [7:0]  a_cfg_data;
    logic        a_x_valid, a_x_ready;
    logic [15:0] a_x_vector_flat;
    logic        a_y_valid, a_y_ready;
    logic [47:0] a_result_flat;
    logic [2:0]  a_ovf_flat;
    logic        a_busy;

    logic        b_cfg_valid, b_cfg_ready;
    logic [1:0]  b_cfg_addr;
    logic [7:0]  b_cfg_data;
    logic        b_x_valid, b_x_ready;
    logic [15:0] b_x_vector_flat;
    logic        b_y_valid, b_y_ready;
    logic [31:0] b_result_flat;
    logic [1:0]  b_ovf_flat;
    logic        b_busy;

    int checks   = 0;
    int failures = 0;

    mv_stream_engine #(
        .DW(DW), .ROWS(3), .COLS(2), .ROW_W(2), .COL_W(1), .ACC_W(ACC_W), .SAT(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_addr(a_cfg_addr), .cfg_data(a_cfg_data),
        .x_valid(a_x_valid), .x_ready(a_x_ready), .x_vector_flat(a_x_vector_flat),
        .y_valid(a_y_valid), .y_ready(a_y_ready),
        .result_flat(a_result_flat), .ovf_flat(a_ovf_flat), .busy(a_busy)
    );

    mv_stream_engine #(
        .DW(DW), .ROWS(2), .COLS(2), .ROW_W(1), .COL_W(1), .ACC_W(ACC_W), .SAT(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
        .x_valid(b_x_valid), .x_ready(b_x_ready), .x_vector_flat(b_x_vector_flat),
        .y_valid(b_y_valid), .y_ready(b_y_ready),
        .result_flat(b_result_flat), .ovf_flat(b_ovf_flat), .busy(b_busy)
    );

    // Single comparison point: counts the check and reports any failure.
    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic signed [63:0] aRow(input int r);
        return 64'($signed(a_result_flat[r*ACC_W +: ACC_W]));
    endfunction

    function automatic logic signed [63:0] bRow(input int r);
        return 64'($signed(b_result_flat[r*ACC_W +: ACC_W]));
    endfunction

    // Weight write on instance A, one cycle, starting and ending on a falling edge.
    task automatic cfgA(input int row, input int col, input int data);
        a_cfg_valid = 1'b1;
        a_cfg_addr  = {2'(row), 1'(col)};
        a_cfg_data  = 8'(data);
        @(negedge clk);
        a_cfg_valid = 1'b0;
    endtask

    // Presents a vector on instance A without waiting for acceptance.
    task automatic applyStimulus(input int x0, input int x1);
        a_x_valid       = 1'b1;
        a_x_vector_flat = {8'(x1), 8'(x0)};
    endtask

    // Full vector on instance A: accept, check latency, results, handshake.
    task automatic runVectorA(input string tag, input int x0, input int x1,
                              input int e0, input int e1, input int e2, input int eovf);
        applyStimulus(x0, x1);
        #1;
        checkOutput({tag, ".x_ready"}, 64'(a_x_ready), 64'd1);
        @(negedge clk);
        a_x_valid = 1'b0;
        checkOutput({tag, ".busy_e0"}, 64'(a_busy), 64'd1);
        checkOutput({tag, ".yv_e0"}, 64'(a_y_valid), 64'd0);
        @(negedge clk);
        checkOutput({tag, ".yv_e1"}, 64'(a_y_valid), 64'd0);
        @(negedge clk);
        checkOutput({tag, ".yv_e2"}, 64'(a_y_valid), 64'd1);
        checkOutput({tag, ".row0"}, aRow(0), 64'(e0));
        checkOutput({tag, ".row1"}, aRow(1), 64'(e1));
        checkOutput({tag, ".row2"}, aRow(2), 64'(e2));
        checkOutput({tag, ".ovf"}, 64'(a_ovf_flat), 64'(eovf));
        a_y_ready = 1'b1;
        @(negedge clk);
        a_y_ready = 1'b0;
        checkOutput({tag, ".yv_done"}, 64'(a_y_valid), 64'd0);
        checkOutput({tag, ".busy_done"}, 64'(a_busy), 64'd0);
    endtask

    // Directed sequence; everything is driven and sampled on falling edges.
    initial begin
        rst_n = 1'b0;
        a_cfg_valid = 1'b0; a_cfg_addr = '0; a_cfg_data = '0;
        a_x_valid = 1'b0; a_x_vector_flat = '0; a_y_ready = 1'b0;
        b_cfg_valid = 1'b0; b_cfg_addr = '0; b_cfg_data = '0;
        b_x_valid = 1'b0; b_x_vector_flat = '0; b_y_ready = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst.yv", 64'(a_y_valid), 64'd0);
        checkOutput("rst.busy", 64'(a_busy), 64'd0);
        checkOutput("rst.cfg_ready", 64'(a_cfg_ready), 64'd1);
        checkOutput("rst.x_ready", 64'(a_x_ready), 64'd1);
        checkOutput("rst.result", 64'(a_result_flat), 64'd0);
        checkOutput("rst.ovf", 64'(a_ovf_flat), 64'd0);
        checkOutput("rst.b_result", 64'(b_result_flat), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic products with W = [[1,2],[3,4]], row 2 left at zero.
        cfgA(0, 0, 1); cfgA(0, 1, 2); cfgA(1, 0, 3); cfgA(1, 1, 4);
        runVectorA("v56", 5, 6, 17, 39, 0, 0);
        runVectorA("vneg", -1, 1, 1, 1, 0, 0);

        // Saturation: (-128*-128)*2 = 32768 clamps to 32767 on rows 0 and 1.
        cfgA(0, 0, -128); cfgA(0, 1, -128); cfgA(1, 0, -128); cfgA(1, 1, -128);
        runVectorA("sat", -128, -128, 32767, 32767, 0, 3);

        // Wrapping instance: the same sum wraps to -32768.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                b_cfg_valid = 1'b1;
                b_cfg_addr  = {1'(r), 1'(c)};
                b_cfg_data  = 8'h80;
                @(negedge clk);
            end
        end
        b_cfg_valid = 1'b0;
        b_x_valid = 1'b1;
        b_x_vector_flat = {8'h80, 8'h80};
        @(negedge clk);
        b_x_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("wrap.yv", 64'(b_y_valid), 64'd1);
        checkOutput("wrap.row0", bRow(0), -64'sd32768);
        checkOutput("wrap.row1", bRow(1), -64'sd32768);
        checkOutput("wrap.ovf", 64'(b_ovf_flat), 64'd3);
        b_y_ready = 1'b1;
        @(negedge clk);
        b_y_ready = 1'b0;
        checkOutput("wrap.yv_done", 64'(b_y_valid), 64'd0);

        // Back-pressure with a second vector already pending.
        cfgA(0, 0, 1); cfgA(0, 1, 2); cfgA(1, 0, 3); cfgA(1, 1, 4);
        applyStimulus(5, 6);
        @(negedge clk);
        applyStimulus(-1, 1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp.yv", 64'(a_y_valid), 64'd1);
            checkOutput("bp.row0", aRow(0), 64'd17);
            checkOutput("bp.row1", aRow(1), 64'd39);
            checkOutput("bp.x_ready", 64'(a_x_ready), 64'd0);
            checkOutput("bp.cfg_ready", 64'(a_cfg_ready), 64'd0);
            @(negedge clk);
        end
        a_y_ready = 1'b1;
        @(negedge clk);
        a_y_ready = 1'b0;
        checkOutput("bp.yv_done", 64'(a_y_valid), 64'd0);
        checkOutput("bp.x_ready_idle", 64'(a_x_ready), 64'd1);
        checkOutput("bp.row0_hold", aRow(0), 64'd17);
        @(negedge clk);
        a_x_valid = 1'b0;
        checkOutput("bp.busy_next", 64'(a_busy), 64'd1);
        repeat (2) @(negedge clk);
        checkOutput("bp.yv2", 64'(a_y_valid), 64'd1);
        checkOutput("bp.row0_2", aRow(0), 64'd1);
        checkOutput("bp.row1_2", aRow(1), 64'd1);
        a_y_ready = 1'b1;
        @(negedge clk);
        a_y_ready = 1'b0;

        // Config and vector in the same cycle: config wins, vector follows.
        a_cfg_valid = 1'b1;
        a_cfg_addr  = {2'd0, 1'd0};
        a_cfg_data  = 8'd10;
        applyStimulus(5, 6);
        #1;
        checkOutput("prio.x_ready", 64'(a_x_ready), 64'd0);
        checkOutput("prio.cfg_ready", 64'(a_cfg_ready), 64'd1);
        @(negedge clk);
        a_cfg_valid = 1'b0;
        checkOutput("prio.busy", 64'(a_busy), 64'd0);
        runVectorA("prio", 5, 6, 62, 39, 0, 0);

        // Writes to row 3 do not exist with ROWS=3 and must be dropped.
        cfgA(3, 0, 99); cfgA(3, 1, 99);
        runVectorA("drop", 5, 6, 62, 39, 0, 0);

        // Reset in the middle of a computation.
        applyStimulus(5, 6);
        @(negedge clk);
        a_x_valid = 1'b0;
        checkOutput("mid.busy_pre", 64'(a_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid.yv", 64'(a_y_valid), 64'd0);
        checkOutput("mid.busy", 64'(a_busy), 64'd0);
        checkOutput("mid.cfg_ready", 64'(a_cfg_ready), 64'd1);
        checkOutput("mid.result", 64'(a_result_flat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runVectorA("post", 5, 6, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mv_stream_engine.md
# mv_stream_engine

Weight-stationary signed matrix-vector engine with its own sequencer and valid/ready streaming on both input vector and result. A ROWS×COLS weight matrix is preloaded through an addressed config port, then any number of input vectors are streamed; each yields y = W·x, accumulated column-serially. This is the next-generation, parametrised replacement for the fixed-function start-pulse top level, and adds back-pressure, overflow reporting and selectable saturation.

## Interface
- DW, 8, signed weight/activation width
- ROWS, 4, matrix rows (result elements)
- COLS, 4, matrix columns (input elements), ≥1
- ROW_W, 2, row address bits, 2^ROW_W ≥ ROWS
- COL_W, 2, column address bits, 2^COL_W ≥ COLS
- ACC_W, 20, signed accumulator/result width, ≥ 2*DW
- SAT, 1, 1 = saturating accumulation, 0 = two's-complement wrap

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  weight write request
- cfg_ready  out  1  weight write accepted when high with cfg_valid
- cfg_addr  in  ROW_W+COL_W  {row, col}; row = upper ROW_W bits, col = lower COL_W bits
- cfg_data  in  DW  signed weight
- x_valid  in  1  input vector valid
- x_ready  out  1  input vector accepted when high with x_valid
- x_vector_flat  in  COLS*DW  element c at [c*DW +: DW], signed
- y_valid  out  1  result valid
- y_ready  in  1  result consumed when high with y_valid
- result_flat  out  ROWS*ACC_W  row r at [r*ACC_W +: ACC_W], signed
- ovf_flat  out  ROWS  bit r set if row r overflowed during this vector
- busy  out  1  high in COMPUTE and OUTPUT

## Operation
- States: IDLE, COMPUTE, OUTPUT. Reset → IDLE.
- cfg_ready = (state==IDLE). x_ready = (state==IDLE) && !cfg_valid — config has priority in the same cycle.
- Config write: on cfg_valid&&cfg_ready, W[row][col] ← cfg_data. Row ≥ ROWS or col ≥ COLS: write dropped, no other effect. Weights persist across vectors until overwritten or reset.
- Vector accept (IDLE, x_valid&&x_ready): latch x, clear all accumulators and ovf bits, col counter ← 0, → COMPUTE.
- COMPUTE: each cycle, for every r: acc[r] ← acc[r] + W[r][col]*x[col] (2*DW-bit signed product, sign-extended). col increments; after col==COLS-1 processed → OUTPUT.
- Overflow: sum evaluated at ACC_W+1 bits; if outside ACC_W signed range, ovf[r] ← 1 (sticky for this vector); SAT=1 clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1); SAT=0 keeps low ACC_W bits.
- OUTPUT: y_valid=1; result_flat = acc, ovf_flat = ovf, both stable while y_valid&&!y_ready. On y_ready → IDLE; result_flat/ovf_flat hold last values in IDLE (y_valid=0).
- Weights cannot change during a vector (cfg_ready=0 while busy).

## Timing
- Reset (async assert, any state): state IDLE, all weights 0, acc 0, result_flat 0, ovf_flat 0, y_valid 0, busy 0, cfg_ready 1; x_ready = !cfg_valid. Any in-flight vector is discarded.
- Vector accepted at edge E0 → accumulate at edges E1..E_COLS → y_valid high in the cycle following E_COLS (COLS cycles after accept edge).
- Result handshake at edge E_h → x_ready high from the cycle after E_h. Peak throughput: one vector per COLS+2 cycles.
- Config write takes effect at the accepting edge; a vector accepted on the next edge uses the new weight.
- busy rises cycle after accept, falls cycle after result handshake.

## Test plan
- DW=8, ROWS=COLS=2, ACC_W=16: preload W=[[1,2],[3,4]], send x=[5,6] → result row0=17, row1=39, ovf=00, y_valid exactly 2 cycles after accept; then x=[-1,1] → 1, 1.
- SAT=1, W all -128, x=[-128,-128] → row0 = 32767, ovf bit 1; same with SAT=0 → -32768, ovf bit 1.
- Back-pressure: hold y_ready=0 for 5 cycles with next x_valid pending → result_flat stable, x_ready=0, cfg_ready=0; after y_ready pulse, pending vector accepted on next edge.
- cfg_valid and x_valid together in IDLE writing W[0][0]=10 → x_ready=0 that cycle, write done; vector accepted next cycle and row0 reflects 10.
- ROWS=3, ROW_W=2: write to row 3 → dropped; all results unchanged from prior weights.
- Assert rst_n mid-COMPUTE → y_valid=0, busy=0 immediately; after release, x=[5,6] without preload → result 0, 0.
